grid_server: RTL

- Responder end of the grid lookup interface. Requesters such as player_updater drive grid_x/grid_y and read back a 3-bit cell code.
- Owns the 64x32 level grid: 2048 cells x 3 bits, synchronous single-port RAM.
- Serves two read clients, port A (player update) and port B (raycaster/renderer), plus one write client (level loader).
- After reset, autonomously initialises the grid to a walled empty room.

---
 rtl/grid_defs_pkg.sv | 41 ++++
 rtl/grid_ram.sv | 26 ++
 rtl/grid_server.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/grid_defs_pkg.sv
// Shared definitions for the level grid: geometry, cell codes, FSM states and
// address/initial-content helpers.
package grid_defs;

  localparam int unsigned GRID_W    = 64;
  localparam int unsigned GRID_H    = 32;
  localparam int unsigned CELL_BITS = 3;
  localparam int unsigned X_BITS    = 6;
  localparam int unsigned Y_BITS    = 5;
  localparam int unsigned ADDR_BITS = X_BITS + Y_BITS;
  localparam int unsigned CELLS     = GRID_W * GRID_H;

  // Codes 2..7 are reserved for doors, exits and other special cells.
  localparam logic [CELL_BITS-1:0] EMPTY_CELL = 3'd0;
  localparam logic [CELL_BITS-1:0] WALL_CELL  = 3'd1;

  localparam logic [X_BITS-1:0]    X_MAX     = '1;
  localparam logic [Y_BITS-1:0]    Y_MAX     = '1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [0:0] {
    StInit,
    StServe
  } state_e;

  // Row-major RAM address: y selects the row, x the column.
  function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [X_BITS-1:0] x,
                                                     input logic [Y_BITS-1:0] y);
    return {y, x};
  endfunction

  // Content written by the init sweep: a wall ring around an empty room.
  function automatic logic [CELL_BITS-1:0] init_cell(input logic [X_BITS-1:0] x,
                                                     input logic [Y_BITS-1:0] y);
    if ((x == '0) || (x == X_MAX) || (y == '0) || (y == Y_MAX)) begin
      return WALL_CELL;
    end
    return EMPTY_CELL;
  endfunction

endpackage

// File: rtl/grid_ram.sv
// 2048 x 3 single-port synchronous RAM with registered read data. Kept free of
// reset and byte enables so it maps onto a block RAM.
module grid_ram
  import grid_defs::*;
(
  input  logic                 clock,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [CELL_BITS-1:0] i_wdata,
  output logic [CELL_BITS-1:0] o_rdata
);

  logic [CELL_BITS-1:0] r_mem [CELLS];
  logic [CELL_BITS-1:0] r_rdata;

  // One access per cycle: optional write, read data registered (read-first).
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/grid_server.sv
// Grid lookup responder: owns the level RAM, fills it with a walled room after
// reset, then serves one loader write port and two round-robin read ports.
module grid_server
  import grid_defs::*;
(
  input  logic                 clock,
  input  logic                 reset,
  output logic                 init_busy,
  input  logic                 a_req,
  input  logic [X_BITS-1:0]    a_x,
  input  logic [Y_BITS-1:0]    a_y,
  output logic                 a_ack,
  output logic [CELL_BITS-1:0] a_data,
  input  logic                 b_req,
  input  logic [X_BITS-1:0]    b_x,
  input  logic [Y_BITS-1:0]    b_y,
  output logic                 b_ack,
  output logic [CELL_BITS-1:0] b_data,
  input  logic                 wr_en,
  input  logic [X_BITS-1:0]    wr_x,
  input  logic [Y_BITS-1:0]    wr_y,
  input  logic [CELL_BITS-1:0] wr_data,
  output logic                 wr_ack
);

  state_e               r_state;
  state_e               w_state_next;
  logic [ADDR_BITS-1:0] r_init_cnt;
  logic [ADDR_BITS-1:0] w_init_cnt_next;

  // r_rr_b: round-robin pointer, 1 means port B wins the next tie.
  logic                 r_rr_b;
  logic                 w_rr_b_next;

  // Ack registers double as the outstanding-grant flags: a grant at edge N
  // raises the ack for cycle N+1 and blocks re-grant until edge N+1.
  logic                 r_a_ack;
  logic                 r_b_ack;
  logic                 r_wr_ack;
  logic [CELL_BITS-1:0] r_a_hold;
  logic [CELL_BITS-1:0] r_b_hold;

  logic                 w_serve;
  logic                 w_a_elig;
  logic                 w_b_elig;
  logic                 w_wr_go;
  logic                 w_grant_a;
  logic                 w_grant_b;

  logic                 w_ram_we;
  logic [ADDR_BITS-1:0] w_ram_addr;
  logic [CELL_BITS-1:0] w_ram_wdata;
  logic [CELL_BITS-1:0] w_rdata;

  assign w_serve  = (r_state == StServe);
  assign w_a_elig = w_serve && a_req && !r_a_ack;
  assign w_b_elig = w_serve && b_req && !r_b_ack;

  // FSM state and init sweep counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  // Next state, arbitration and RAM port mux; writes outrank reads.
  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_rr_b_next     = r_rr_b;
    w_wr_go         = 1'b0;
    w_grant_a       = 1'b0;
    w_grant_b       = 1'b0;
    w_ram_we        = 1'b0;
    w_ram_addr      = r_init_cnt;
    w_ram_wdata     = EMPTY_CELL;

    unique case (r_state)
      StInit: begin
        w_ram_we        = 1'b1;
        w_ram_addr      = r_init_cnt;
        w_ram_wdata     = init_cell(r_init_cnt[X_BITS-1:0],
                                    r_init_cnt[ADDR_BITS-1:X_BITS]);
        w_init_cnt_next = r_init_cnt + 1'b1;
        if (r_init_cnt == LAST_ADDR) begin
          w_state_next = StServe;
        end
      end
      StServe: begin
        // The cycle carrying wr_ack is the loader's chance to drop wr_en.
        if (wr_en && !r_wr_ack) begin
          w_wr_go     = 1'b1;
          w_ram_we    = 1'b1;
          w_ram_addr  = cell_addr(wr_x, wr_y);
          w_ram_wdata = wr_data;
        end else if (w_a_elig && w_b_elig) begin
          w_grant_a   = !r_rr_b;
          w_grant_b   = r_rr_b;
          w_rr_b_next = !r_rr_b;
        end else begin
          w_grant_a = w_a_elig;
          w_grant_b = w_b_elig;
        end

        if (w_grant_a) begin
          w_ram_addr = cell_addr(a_x, a_y);
        end else if (w_grant_b) begin
          w_ram_addr = cell_addr(b_x, b_y);
        end
      end
      default: begin
        w_state_next = StInit;
      end
    endcase
  end

  // Ack pulses, round-robin pointer and held read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_b   <= 1'b0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_wr_ack <= 1'b0;
      r_a_hold <= '0;
      r_b_hold <= '0;
    end else begin
      r_rr_b   <= w_rr_b_next;
      r_a_ack  <= w_grant_a;
      r_b_ack  <= w_grant_b;
      r_wr_ack <= w_wr_go;
      if (r_a_ack) begin
        r_a_hold <= w_rdata;
      end
      if (r_b_ack) begin
        r_b_hold <= w_rdata;
      end
    end
  end

  grid_ram u_grid_ram (
    .clock   (clock),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  // RAM output is only meaningful in the ack cycle; otherwise show the last value.
  assign init_busy = (r_state == StInit);
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign wr_ack    = r_wr_ack;
  assign a_data    = r_a_ack ? w_rdata : r_a_hold;
  assign b_data    = r_b_ack ? w_rdata : r_b_hold;

endmodule
